// File: rtl/bram_port_master.sv
// Initiator for one native BRAM port: valid/ready requests in, credit-protected FWFT response FIFO out.
// Define BRAM_PORT_MASTER_WRACK_EN to make writes return a response (WRITE_FIRST read-back data).
module bram_port_master #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    logic              rsta_n_sync;
    logic              fire;
    logic              rsp_req;
    logic [RD_LAT-1:0] lat_sr;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     occupancy;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       fifo_count;
    logic              push;
    logic              pop;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) rsta_n_sync <= 1'b0;
        else         rsta_n_sync <= 1'b1;
    end

    assign fire = req_valid & req_ready;

`ifdef BRAM_PORT_MASTER_WRACK_EN
    assign rsp_req = fire;
`else
    assign rsp_req = fire & ~req_we;
`endif

    assign ena   = fire;
    assign wea   = fire & req_we;
    assign addra = fire ? req_addr  : '0;
    assign dina  = fire ? req_wdata : '0;

    // Each set bit marks a response whose douta arrives when the bit reaches the tail.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            lat_sr <= '0;
        end else begin
            lat_sr[0] <= rsp_req;
            for (int i = 1; i < RD_LAT; i++) lat_sr[i] <= lat_sr[i-1];
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(lat_sr[i]);
    end

    // Occupancy ignores a same-cycle pop so rsp_ready never reaches req_ready combinationally.
    assign occupancy = CW'(fifo_count) + inflight;
    assign req_ready = rsta_n_sync & (occupancy < CW'(FIFO_DEPTH));

    assign push      = lat_sr[RD_LAT-1];
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_valid = (fifo_count != '0);
    assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clka) begin
        if (push) fifo_mem[wr_ptr] <= douta;
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clka) disable iff (!rsta_n)
        !(push && fifo_count == (PW+1)'(FIFO_DEPTH)));

endmodule

// File: tb/tb_bram_port_master.sv
// Directed bench for bram_port_master with a WRITE_FIRST BRAM model and an in-order response scoreboard.
// Honours BRAM_PORT_MASTER_WRACK_EN when the design is built with it.
module tb_bram_port_master;

    logic        clka;
    logic        rsta_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        ena;
    logic        wea;
    logic [3:0]  addra;
    logic [31:0] dina;
    logic [31:0] douta;

    int tests = 0;
    int fails = 0;
    int rsp_count = 0;
    int acc_count = 0;
    logic [31:0] last_rdata = '0;
    logic [31:0] bram [16];
    logic [31:0] model_mem [16];
    logic [31:0] exp_q [$];

    bram_port_master dut (
        .clka      (clka),
        .rsta_n    (rsta_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ena       (ena),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .douta     (douta)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // WRITE_FIRST BRAM with one cycle of read latency.
    always @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                bram[addra] <= dina;
                douta       <= dina;
            end else begin
                douta <= bram[addra];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [3:0] a,
                                 input logic [31:0] d, input logic rr);
        @(posedge clka);
        #2;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
    endtask

    // Scoreboard: handshakes take effect at the next rising edge, so sample them mid-cycle.
    always @(negedge clka) begin
        if (!rsta_n) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) checkOutput("rsp_unexpected", 32'd1, 32'd0);
                else                   checkOutput("rsp_data", rsp_rdata, exp_q.pop_front());
                rsp_count++;
                last_rdata = rsp_rdata;
            end
            if (req_valid && req_ready) begin
                acc_count++;
                if (!req_we) begin
                    exp_q.push_back(model_mem[req_addr]);
                end else begin
                    model_mem[req_addr] = req_wdata;
`ifdef BRAM_PORT_MASTER_WRACK_EN
                    exp_q.push_back(req_wdata);
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rsta_n    = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd5;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;

        // Reset held with a request pending
        repeat (3) @(posedge clka);
        @(negedge clka);
        checkOutput("rst_ena", 32'(ena), 32'd0);
        checkOutput("rst_wea", 32'(wea), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_addra", 32'(addra), 32'd0);
        checkOutput("rst_dina", dina, 32'd0);
        @(posedge clka);
        #2;
        rsta_n    = 1'b1;
        req_valid = 1'b0;
        @(negedge clka);
        checkOutput("release_ready_early", 32'(req_ready), 32'd0);
        @(negedge clka);
        checkOutput("release_ready", 32'(req_ready), 32'd1);

        // Fill memory with a known pattern
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 4'(i), 32'hA500_0000 | 32'(i), 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput("fill_accepts", 32'(acc_count), 32'd16);

        // Write then read address 3
        applyStimulus(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1);
        @(negedge clka);
        checkOutput("wr_ena", 32'(ena), 32'd1);
        checkOutput("wr_wea", 32'(wea), 32'd1);
        checkOutput("wr_addra", 32'(addra), 32'd3);
        checkOutput("wr_dina", dina, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 4'd3, 32'd0, 1'b1);
        @(negedge clka);
        checkOutput("rd_ena", 32'(ena), 32'd1);
        checkOutput("rd_wea", 32'(wea), 32'd0);
        checkOutput("rd_addra", 32'(addra), 32'd3);
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        @(negedge clka);
`ifdef BRAM_PORT_MASTER_WRACK_EN
        checkOutput("wr_ack_valid", 32'(rsp_valid), 32'd1);
`else
        checkOutput("no_wr_rsp", 32'(rsp_valid), 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        @(negedge clka);
        checkOutput("rd_lat_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd_lat_data", rsp_rdata, 32'hDEADBEEF);
        repeat (2) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

        // Streamed reads at full rate
        base = rsp_count;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i), 32'd0, 1'b1);
            @(negedge clka);
            checkOutput("stream_ready", 32'(req_ready), 32'd1);
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        @(negedge clka);
        checkOutput("stream_count", 32'(rsp_count - base), 32'd16);
        checkOutput("stream_last", last_rdata, 32'hA500_000F);

        // Backpressure: only FIFO_DEPTH reads may be outstanding
        base = acc_count;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 4'(i), 32'd0, 1'b0);
        @(negedge clka);
        checkOutput("bp_accepts", 32'(acc_count - base), 32'd4);
        checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
        base = rsp_count;
        for (int k = 0; k < 20 && rsp_count < base + 4; k++) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput("bp_drain_count", 32'(rsp_count - base), 32'd4);
        checkOutput("bp_drain_last", last_rdata, 32'hDEADBEEF);

        // Reset with two reads in flight
        applyStimulus(1'b1, 1'b0, 4'd1, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd2, 32'd0, 1'b0);
        @(posedge clka);
        #2;
        rsta_n    = 1'b0;
        req_valid = 1'b0;
        @(negedge clka);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_ready", 32'(req_ready), 32'd0);
        base = rsp_count;
        @(posedge clka);
        #2;
        rsta_n = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput("no_stale_rsp", 32'(rsp_count - base), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd7, 32'd0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        @(negedge clka);
        checkOutput("post_rst_count", 32'(rsp_count - base), 32'd1);
        checkOutput("post_rst_data", last_rdata, 32'hA500_0007);

`ifdef BRAM_PORT_MASTER_WRACK_EN
        // Write acknowledgements consume credit and return the written data
        base = rsp_count;
        applyStimulus(1'b1, 1'b1, 4'd5, 32'h12345678, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        @(negedge clka);
        checkOutput("wrack_count", 32'(rsp_count - base), 32'd1);
        checkOutput("wrack_data", last_rdata, 32'h12345678);
        base = acc_count;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 4'(8 + i), 32'h5A00_0000 | 32'(i), 1'b0);
        @(negedge clka);
        checkOutput("wrack_credit", 32'(acc_count - base), 32'd4);
        checkOutput("wrack_ready_low", 32'(req_ready), 32'd0);
        base = rsp_count;
        for (int k = 0; k < 20 && rsp_count < base + 4; k++) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput("wrack_drain", 32'(rsp_count - base), 32'd4);
`endif

        repeat (2) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
